vga_frame_ctrl: RTL

Display-mode controller that sits between the board switches and the VGA text path (sync generator plus text generator). It debounces `swt1`..`swt3` and resolves them into a 2-bit display mode. It then applies any mode change only on frame boundaries, forcing a black-out window so the text generator never shows a torn or half-switched frame. `mode` drives the text generator's page select; `blank` gates the RGB buffer to black.

---
 rtl/vga_frame_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/vga_frame_ctrl.sv
// vga_frame_ctrl
//   Debounces three board switches into a 2-bit display-mode request and
//   applies mode changes only on frame boundaries. The RGB path is forced to
//   black for BLANK_FRAMES+1 frames around every change, so the text
//   generator never shows a torn or half-switched page.
//
// Ports
//   clk         in   pixel-domain clock (same net as the sync generator)
//   reset       in   synchronous, active-low reset
//   swt1..swt3  in   raw asynchronous switch inputs (swt1 has top priority)
//   vsync       in   vertical sync from the sync generator
//   mode        out  committed display mode (text page select)
//   blank       out  1 = force RGB to black
//   busy        out  1 while a mode change is in progress (FSM not IDLE)
//   change_done out  one-cycle pulse when a mode change completes
//
// Handshake: there is no valid/ready pair here. A request is simply a
// debounced switch level; it is held, not consumed, so a request that
// appears while a change is in flight is picked up again from IDLE.
module vga_frame_ctrl #(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter int   CNT_W           = 19,
    parameter int   BLANK_FRAMES    = 2,
    parameter logic VSYNC_ACTIVE    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       swt1,
    input  logic       swt2,
    input  logic       swt3,
    input  logic       vsync,
    output logic [1:0] mode,
    output logic       blank,
    output logic       busy,
    output logic       change_done
);

    // fcnt only has to reach BLANK_FRAMES-1.
    localparam int FW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0]    FCNT_LAST = FW'(BLANK_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        BLANKING   = 2'd2,
        COMMIT     = 2'd3
    } state_t;

    // ---------------- switch synchronisers and debouncers ----------------
    logic [2:0]            raw;
    logic [2:0]            sync1;
    logic [2:0]            sync2;
    logic [2:0]            stable;
    logic [2:0][CNT_W-1:0] cnt;

    assign raw = {swt3, swt2, swt1};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    // Value has differed for DEBOUNCE_CYCLES edges: accept it.
                    stable[i] <= ~stable[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Priority resolve: swt1 > swt2 > swt3 > none.
    logic [1:0] req;
    always_comb begin
        req = 2'd0;
        if (stable[0])      req = 2'd1;
        else if (stable[1]) req = 2'd2;
        else if (stable[2]) req = 2'd3;
    end

    // ---------------- frame start detect ----------------
    // vs_q resets to the inactive level so a vsync already active at reset
    // release is treated as a frame start.
    logic vs_q;
    logic frame_start;

    always_ff @(posedge clk) begin
        if (!reset) vs_q <= ~VSYNC_ACTIVE;
        else        vs_q <= vsync;
    end

    assign frame_start = (vsync == VSYNC_ACTIVE) && (vs_q != VSYNC_ACTIVE);

    // ---------------- mode change FSM ----------------
    state_t     state_q, state_d;
    logic [1:0] target_q, target_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [1:0] mode_d;
    logic       blank_d;
    logic       done_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            target_q    <= 2'd0;
            fcnt_q      <= '0;
            mode        <= 2'd0;
            blank       <= 1'b0;
            busy        <= 1'b0;
            change_done <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            fcnt_q      <= fcnt_d;
            mode        <= mode_d;
            blank       <= blank_d;
            busy        <= (state_d != IDLE);
            change_done <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        fcnt_d   = fcnt_q;
        mode_d   = mode;
        blank_d  = blank;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                blank_d = 1'b0;
                if (req != mode) begin
                    target_d = req;
                    state_d  = WAIT_FRAME;
                end
            end

            WAIT_FRAME: begin
                blank_d = 1'b0;
                // Cancel takes priority over a coincident frame start.
                if (req == mode) begin
                    state_d = IDLE;
                end else begin
                    target_d = req;
                    if (frame_start) begin
                        blank_d = 1'b1;
                        fcnt_d  = '0;
                        state_d = BLANKING;
                    end
                end
            end

            BLANKING: begin
                blank_d = 1'b1;
                if (frame_start) begin
                    if (fcnt_q == FCNT_LAST) begin
                        mode_d  = target_q;
                        state_d = COMMIT;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end

            COMMIT: begin
                blank_d = 1'b1;
                if (frame_start) begin
                    blank_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
